// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and default parameters for the pulse stretcher
package pulse_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} pstate_t;

  localparam int W_BITS_DEF   = 8;
  localparam int CNT_W_DEF    = 16;
  localparam int PEND_MAX_DEF = 7;

endpackage

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - detection input, controls and status outputs of the pulse stretcher
interface pulse_stretcher_if #(
  parameter int W_BITS   = pulse_pkg::W_BITS_DEF,
  parameter int CNT_W    = pulse_pkg::CNT_W_DEF,
  parameter int PEND_MAX = pulse_pkg::PEND_MAX_DEF
);

  localparam int PW = $clog2(PEND_MAX + 1);

  logic              detected_i;
  logic [W_BITS-1:0] pulse_width;
  logic [W_BITS-1:0] gap;
  logic              clear;
  logic              pulse_o;
  logic              busy_o;
  logic [PW-1:0]     pending_o;
  logic [CNT_W-1:0]  event_cnt_o;
  logic              overflow_o;

  modport master (
    output detected_i, pulse_width, gap, clear,
    input  pulse_o, busy_o, pending_o, event_cnt_o, overflow_o
  );

  modport slave (
    input  detected_i, pulse_width, gap, clear,
    output pulse_o, busy_o, pending_o, event_cnt_o, overflow_o
  );

endinterface

// File: rtl/pulse_stretcher_edge_detect.sv
// rtl/pulse_stretcher_edge_detect.sv - rising-edge detector for a level input
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // remember last cycle's level so a held-high input yields a single rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches each detection into a pulse plus guard gap, queueing overlaps
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int W_BITS   = W_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PEND_MAX = PEND_MAX_DEF
) (
  input logic              clk,
  input logic              rst_n,
  pulse_stretcher_if.slave bus
);

  localparam int            PW        = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  pstate_t           state, state_nxt;
  logic [W_BITS-1:0] tmr, tmr_nxt;
  logic              evt;
  logic              deq;
  logic              enq;
  logic              drop;
  logic              has_pend;
  logic [PW-1:0]     pending;
  logic [CNT_W-1:0]  event_cnt;
  logic              overflow;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (bus.detected_i),
    .rise  (evt)
  );

  assign has_pend = (pending != '0);

  // An event is queued whenever it cannot itself start the pulse: the block is busy,
  // or older queued work exists (the queued one starts first, so net pending holds).
  assign enq  = evt & ((state != IDLE) | has_pend);
  assign drop = enq & ~deq & (pending == PEND_FULL);

  // state and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // next-state and timer load/decrement; width and gap are only read at load time
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    deq       = 1'b0;
    case (state)
      IDLE: begin
        if (evt || has_pend) begin
          state_nxt = PULSE;
          tmr_nxt   = (bus.pulse_width == '0) ? '0 : bus.pulse_width - 1'b1;
          deq       = has_pend;
        end
      end
      PULSE: begin
        if (tmr == '0) begin
          if (bus.gap == '0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            tmr_nxt   = bus.gap - 1'b1;
          end
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0) state_nxt = IDLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pending queue, event count and sticky overflow; clear wins over a same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else if (bus.clear) begin
      pending   <= '0;
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (evt)  event_cnt <= event_cnt + 1'b1;
      if (drop) overflow  <= 1'b1;
      if (enq && !deq && !drop) pending <= pending + 1'b1;
      else if (deq && !enq)     pending <= pending - 1'b1;
    end
  end

  assign bus.pulse_o     = (state == PULSE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.pending_o   = pending;
  assign bus.event_cnt_o = event_cnt;
  assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

  logic clk;
  logic rst_n;

  int total;
  int passed;

  pulse_stretcher_if #(.W_BITS(8), .CNT_W(16), .PEND_MAX(7)) bus ();

  pulse_stretcher #(.W_BITS(8), .CNT_W(16), .PEND_MAX(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    int          pulses;
    int          peak;
    logic [29:0] hist;
    logic [29:0] exp_hist;

    total  = 0;
    passed = 0;

    rst_n           = 1'b0;
    bus.detected_i  = 1'b0;
    bus.pulse_width = 8'd3;
    bus.gap         = 8'd2;
    bus.clear       = 1'b0;

    // reset state
    tick(3);
    chk("rst_pulse", 32'(bus.pulse_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_pending", 32'(bus.pending_o), 32'd0);
    chk("rst_cnt", 32'(bus.event_cnt_o), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);

    // single detection, W=3 G=2; mid-pulse width change must not matter
    bus.detected_i = 1'b1;
    tick(1);
    chk("t1_pulse_start", 32'(bus.pulse_o), 32'd1);
    chk("t1_busy_start", 32'(bus.busy_o), 32'd1);
    chk("t1_cnt", 32'(bus.event_cnt_o), 32'd1);
    chk("t1_pending", 32'(bus.pending_o), 32'd0);
    bus.detected_i  = 1'b0;
    bus.pulse_width = 8'd8;
    tick(2);
    chk("t1_pulse_last", 32'(bus.pulse_o), 32'd1);
    tick(1);
    chk("t1_pulse_end", 32'(bus.pulse_o), 32'd0);
    chk("t1_gap_busy0", 32'(bus.busy_o), 32'd1);
    tick(1);
    chk("t1_gap_busy1", 32'(bus.busy_o), 32'd1);
    tick(1);
    chk("t1_idle", 32'(bus.busy_o), 32'd0);
    bus.pulse_width = 8'd3;

    // held-high input gives exactly one pulse
    bus.detected_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      pulses += int'(bus.pulse_o);
    end
    chk("t2_pulse_cycles", 32'(pulses), 32'd3);
    chk("t2_cnt", 32'(bus.event_cnt_o), 32'd2);
    chk("t2_busy", 32'(bus.busy_o), 32'd0);
    bus.detected_i = 1'b0;
    tick(2);
    chk("t2_cnt_fall", 32'(bus.event_cnt_o), 32'd2);

    // four events two cycles apart, W=5 G=0: queued pulses separated by one idle cycle
    bus.pulse_width = 8'd5;
    bus.gap         = 8'd0;
    peak            = 0;
    hist            = '0;
    for (int i = 0; i < 30; i++) begin
      bus.detected_i = (i < 8) && (i % 2 == 0);
      tick(1);
      hist[i] = bus.pulse_o;
      if (int'(bus.pending_o) > peak) peak = int'(bus.pending_o);
      exp_hist[i] = (i % 6 != 5) && (i < 23);
    end
    chk("t3_pulse_train", 32'(hist), 32'(exp_hist));
    chk("t3_pending_peak", 32'(peak), 32'd2);
    chk("t3_cnt", 32'(bus.event_cnt_o), 32'd6);
    chk("t3_pending_end", 32'(bus.pending_o), 32'd0);

    // saturation: 1 starter + 10 queued while busy, then clear mid-pulse
    bus.pulse_width = 8'd50;
    for (int i = 0; i < 22; i++) begin
      bus.detected_i = (i % 2 == 0) && (i <= 20);
      tick(1);
    end
    chk("t4_pending_sat", 32'(bus.pending_o), 32'd7);
    chk("t4_ovf", 32'(bus.overflow_o), 32'd1);
    chk("t4_cnt", 32'(bus.event_cnt_o), 32'd17);
    chk("t4_pulse", 32'(bus.pulse_o), 32'd1);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("t4_clr_cnt", 32'(bus.event_cnt_o), 32'd0);
    chk("t4_clr_pending", 32'(bus.pending_o), 32'd0);
    chk("t4_clr_ovf", 32'(bus.overflow_o), 32'd0);
    chk("t4_clr_pulse", 32'(bus.pulse_o), 32'd1);
    tick(27);
    chk("t4_pulse_last", 32'(bus.pulse_o), 32'd1);
    tick(1);
    chk("t4_pulse_end", 32'(bus.pulse_o), 32'd0);
    chk("t4_busy_end", 32'(bus.busy_o), 32'd0);
    tick(3);
    chk("t4_no_more", 32'(bus.busy_o), 32'd0);

    // width 0 acts as 1; clear beats a same-cycle event for the counters
    bus.pulse_width = 8'd0;
    bus.detected_i  = 1'b1;
    bus.clear       = 1'b1;
    tick(1);
    chk("t5_pulse", 32'(bus.pulse_o), 32'd1);
    chk("t5_cnt_cleared", 32'(bus.event_cnt_o), 32'd0);
    bus.detected_i = 1'b0;
    bus.clear      = 1'b0;
    tick(1);
    chk("t5_pulse_end", 32'(bus.pulse_o), 32'd0);
    chk("t5_busy_end", 32'(bus.busy_o), 32'd0);

    // asynchronous reset in the middle of a pulse with work queued
    bus.pulse_width = 8'd10;
    bus.detected_i  = 1'b1;
    tick(1);
    bus.detected_i = 1'b0;
    tick(1);
    bus.detected_i = 1'b1;
    tick(1);
    chk("t6_pending", 32'(bus.pending_o), 32'd1);
    chk("t6_cnt", 32'(bus.event_cnt_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pulse", 32'(bus.pulse_o), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("t6_rst_pending", 32'(bus.pending_o), 32'd0);
    chk("t6_rst_cnt", 32'(bus.event_cnt_o), 32'd0);
    bus.detected_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("t6_post_idle", 32'(bus.busy_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
